// File: rtl/alu16_exec_if.sv
// ----------------------------------------------------------------------------
// alu16_exec_if
//   Handshake bundle between the decode stage, the ALU execution stage and
//   writeback.
//
//   Input side  (decode -> exec): in_valid, in_ready, in_op, in_a, in_b
//   Output side (exec -> writeback): out_valid, out_ready, out_result,
//                                    out_zero, out_neg, out_carry, out_err
//
//   master : the environment (drives operands and out_ready)
//   slave  : the execution unit (drives in_ready and the result side)
// ----------------------------------------------------------------------------
interface alu16_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_err
    );
endinterface

// File: rtl/alu16_exec_unit.sv
// ----------------------------------------------------------------------------
// alu16_exec_unit
//   Registered single-operation ALU execution stage. Accepts one op over a
//   valid/ready handshake, computes logic/arithmetic results in one cycle and
//   shifts one bit per clock, then holds result + flags until writeback takes
//   them. Only one operation is in flight at a time.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : alu16_exec_if.slave
//              in_valid/in_ready/in_op/in_a/in_b       operand handshake
//              out_valid/out_ready/out_result/flags    result handshake
//
//   Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 SHL, 7 SHR,
//            8 SEL (bit a[b]), 9 PASS b, 10-15 illegal (out_err=1).
// ----------------------------------------------------------------------------
module alu16_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu16_exec_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SEL  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             err;
    } alu_res_t;

    // Single-cycle ops. Shifts only reach here with amount 0, where the
    // result is operand A unchanged and nothing is shifted out.
    function automatic alu_res_t alu_eval(input logic [3:0]       op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        alu_res_t         r;
        logic [WIDTH:0]   sum;
        r   = '0;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            OP_XOR:  r.result = a ^ b;
            OP_NOT:  r.result = ~a;
            OP_ADD:  begin
                r.result = sum[WIDTH-1:0];
                r.carry  = sum[WIDTH];
            end
            OP_SUB:  begin
                r.result = a - b;
                r.carry  = (a < b);
            end
            OP_SHL,
            OP_SHR:  r.result = a;
            OP_SEL:  r.result = {{(WIDTH-1){1'b0}}, a[b[SHW-1:0]]};
            OP_PASS: r.result = b;
            default: r.err    = 1'b1;
        endcase
        return r;
    endfunction

    state_t           state_q,  state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   count_q,  count_d;
    logic             shl_q,    shl_d;
    logic             zero_q,   zero_d;
    logic             neg_q,    neg_d;
    logic             carry_q,  carry_d;
    logic             err_q,    err_d;

    alu_res_t         alu_out;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] shifted;
    logic             shift_out_bit;

    assign alu_out  = alu_eval(bus.in_op, bus.in_a, bus.in_b);
    assign shamt    = bus.in_b[SHW-1:0];
    assign is_shift = (bus.in_op == OP_SHL) || (bus.in_op == OP_SHR);

    // The result register doubles as the shift register while in SHIFT.
    assign shifted       = shl_q ? {result_q[WIDTH-2:0], 1'b0} : {1'b0, result_q[WIDTH-1:1]};
    assign shift_out_bit = shl_q ? result_q[WIDTH-1] : result_q[0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        shl_d    = shl_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                // in_ready_q (not just the state) gates accept, so nothing is
                // taken in the first cycle after reset release.
                if (bus.in_valid && in_ready_q) begin
                    if (is_shift && (shamt != '0)) begin
                        result_d = bus.in_a;
                        count_d  = shamt;
                        shl_d    = (bus.in_op == OP_SHL);
                        zero_d   = 1'b0;
                        neg_d    = 1'b0;
                        carry_d  = 1'b0;
                        err_d    = 1'b0;
                        state_d  = SHIFT;
                    end else begin
                        result_d = alu_out.result;
                        carry_d  = alu_out.carry;
                        err_d    = alu_out.err;
                        // An illegal op reports only out_err, even though the
                        // result word is zero.
                        zero_d   = !alu_out.err && (alu_out.result == '0);
                        neg_d    = alu_out.result[WIDTH-1];
                        state_d  = DONE;
                    end
                end
            end

            SHIFT: begin
                result_d = shifted;
                carry_d  = shift_out_bit;
                count_d  = count_q - SHW'(1);
                // Last shift: flags come from the value being loaded now.
                if (count_q == SHW'(1)) begin
                    zero_d  = (shifted == '0);
                    neg_d   = shifted[WIDTH-1];
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // NOTE: the datapath registers are reset along with the control state so
    // that the result and flags read as zero during reset, not just out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            result_q   <= '0;
            count_q    <= '0;
            shl_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            result_q   <= result_d;
            count_q    <= count_d;
            shl_q      <= shl_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_neg    = neg_q;
    assign bus.out_carry  = carry_q;
    assign bus.out_err    = err_q;

endmodule

// File: tb/tb_alu16_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu16_exec_unit
//   Directed vectors with hand-computed results. The stimulus process pushes
//   the expected response into a queue when it issues an op; a separate
//   monitor pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_alu16_exec_unit;

    typedef struct packed {
        logic [15:0] result;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    exp_t exp_q[$];

    alu16_exec_if #(.WIDTH(16)) bus ();

    alu16_exec_unit #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare on every output handshake, flag any overlap of
    // in_ready with out_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.in_ready) begin
                errors++;
                $display("FAIL ready_while_valid actual=1 required=0");
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", 32'(bus.out_result), 32'(e.result));
                    check("zero",   32'(bus.out_zero),   32'(e.zero));
                    check("neg",    32'(bus.out_neg),    32'(e.neg));
                    check("carry",  32'(bus.out_carry),  32'(e.carry));
                    check("err",    32'(bus.out_err),    32'(e.err));
                end
            end
        end
    end

    // Issue one op, check its latency, optionally stall writeback for `hold`
    // cycles, then wait for the handshake to complete.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic z, input logic n,
                        input logic c, input logic e, input int lat, input int hold);
        exp_t x;
        int   k;
        x = {r, z, n, c, e};
        bus.out_ready = (hold == 0);
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(x);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        // Operand changes after accept must not matter.
        bus.in_valid = 1'b0;
        bus.in_op    = 4'd4;
        bus.in_a     = 16'hDEAD;
        bus.in_b     = 16'hBEEF;
        k = 1;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), 32'(lat));
        if (hold > 0) begin
            // A request offered while busy must be ignored.
            bus.in_valid = 1'b1;
            bus.in_op    = 4'd9;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_result", 32'(bus.out_result), 32'(r));
                check("hold_valid",  32'(bus.out_valid),  32'd1);
                check("hold_ready",  32'(bus.in_ready),   32'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        k = 0;
        while (bus.out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("handshake_done", 32'(bus.out_valid), 32'd0);
        check("ready_after",    32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        int k;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.out_result), 32'd0);
        check("rst_flags", 32'({bus.out_zero, bus.out_neg, bus.out_carry, bus.out_err}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

        //    op     a         b         result    z     n     c     e    lat hold
        send(4'd4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1,  0); // ADD wrap
        send(4'd5, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1,  0); // SUB borrow
        send(4'd2, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0); // XOR
        send(4'd6, 16'h8001, 16'h000F, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 16, 0); // SHL 15
        send(4'd7, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2,  0); // SHR 1
        send(4'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1,  5); // AND, stall
        send(4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0); // illegal
        send(4'd8, 16'h0100, 16'h0008, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0); // SEL
        send(4'd1, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0); // OR
        send(4'd3, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 1,  0); // NOT
        send(4'd9, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1,  0); // PASS 0
        send(4'd6, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0); // SHL by 0
        send(4'd4, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1,  0); // ADD overflow
        send(4'd7, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 5,  0); // SHR 4

        // Reset in the middle of a shift: no result may ever appear.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'd6;
        bus.in_a     = 16'h00FF;
        bus.in_b     = 16'h000A;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midshift_busy", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midshift_rst_result", 32'(bus.out_result), 32'd0);
        check("midshift_rst_valid",  32'(bus.out_valid),  32'd0);
        check("midshift_rst_ready",  32'(bus.in_ready),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) k++;
        end
        check("no_stale_result", 32'(k), 32'd0);
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
